// File: rtl/sw_demux_pkg.sv
// Shared types and LEDR/SW bit positions for the switch demux capture block.
package sw_demux_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} db_state_t;

  localparam int SEL_BIT  = 9;
  localparam int X_LSB    = 0;
  localparam int Y_LSB    = 4;
  localparam int HELD_LED = 8;
  localparam int TGT_LED  = 9;
endpackage

// File: rtl/sw_demux_key_debounce.sv
// Push-button debouncer: press and release each need DEBOUNCE_CYCLES stable cycles;
// accept pulses once per debounced press.
module key_debounce
  import sw_demux_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_p,
  output logic accept,
  output logic held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  db_state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      IDLE: begin
        if (key_p) begin
          nstate = PRESS_DB;
          ncnt   = CW'(1);
        end
      end
      PRESS_DB: begin
        if (!key_p) begin
          nstate = IDLE;
          ncnt   = '0;
        end else if (cnt == LAST) begin
          nstate = HELD;
          ncnt   = '0;
        end else begin
          ncnt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!key_p) begin
          nstate = REL_DB;
          ncnt   = CW'(1);
        end
      end
      REL_DB: begin
        if (key_p) begin
          nstate = HELD;
          ncnt   = '0;
        end else if (cnt == LAST) begin
          nstate = IDLE;
          ncnt   = '0;
        end else begin
          ncnt = cnt + CW'(1);
        end
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // accept fires in the last stable press cycle; the capture lands on the next edge
  always_comb begin
    accept = (state == PRESS_DB) && key_p && (cnt == LAST);
    held   = (state == HELD) || (state == REL_DB);
  end
endmodule

// File: rtl/sw_demux_capture.sv
// Routes the switch data word into channel X or Y (chosen by SW[9]) on each debounced
// key press; both channels, the held flag and the last target are shown on LEDR.
module sw_demux_capture
  import sw_demux_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [9:0] SW,
  input  logic       KEY_N,
  output logic [9:0] LEDR
);
  generate
    if (WIDTH < 1 || WIDTH > 4) begin : g_bad_width
      $error("sw_demux_capture: WIDTH must be 1..4");
    end
  endgenerate

  logic [1:0][WIDTH-1:0] d_pipe;
  logic [1:0]            sel_pipe;
  logic [1:0]            key_pipe;
  logic                  key_p, accept, held;
  logic [WIDTH-1:0]      x_q, y_q;
  logic                  tgt_q;
  logic                  sw_unused;

  assign sw_unused = ^SW;

  // key synchronizer idles released (1) so reset never looks like a press edge
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      d_pipe   <= '0;
      sel_pipe <= '0;
      key_pipe <= 2'b11;
    end else begin
      d_pipe   <= {d_pipe[0], SW[WIDTH-1:0]};
      sel_pipe <= {sel_pipe[0], SW[SEL_BIT]};
      key_pipe <= {key_pipe[0], KEY_N};
    end
  end

  assign key_p = ~key_pipe[1];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .key_p    (key_p),
    .accept   (accept),
    .held     (held)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q   <= '0;
      y_q   <= '0;
      tgt_q <= 1'b0;
    end else if (accept) begin
      if (sel_pipe[1]) y_q <= d_pipe[1];
      else             x_q <= d_pipe[1];
      tgt_q <= sel_pipe[1];
    end
  end

  always_comb begin
    LEDR                    = '0;
    LEDR[X_LSB +: WIDTH]    = x_q;
    LEDR[Y_LSB +: WIDTH]    = y_q;
    LEDR[HELD_LED]          = held;
    LEDR[TGT_LED]           = tgt_q;
  end
endmodule

// File: tb/tb_sw_demux_capture.sv
// Bench for sw_demux_capture (WIDTH=4, DEBOUNCE_CYCLES=4): directed table, corner
// sequences, then random key/switch traffic against a run-length reference model.
module tb_sw_demux_capture;
  localparam int N = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic [9:0] SW;
  logic       KEY_N;
  logic [9:0] LEDR;

  int vectors = 0;
  int fails   = 0;

  sw_demux_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(N)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .SW       (SW),
    .KEY_N    (KEY_N),
    .LEDR     (LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference: the key is debounced as "N consecutive synchronized samples that
  // disagree with the current debounced level flip it"; a 0->1 flip captures.
  logic [1:0] mk;
  logic [3:0] md1, md2;
  logic       ms1, ms2;
  logic [3:0] mx, my;
  logic       mt, mheld;
  int         mrun;

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mk <= 2'b11; md1 <= '0; md2 <= '0; ms1 <= 1'b0; ms2 <= 1'b0;
      mx <= '0; my <= '0; mt <= 1'b0; mheld <= 1'b0; mrun <= 0;
    end else begin
      mk  <= {mk[0], KEY_N};
      md1 <= SW[3:0];
      md2 <= md1;
      ms1 <= SW[9];
      ms2 <= ms1;
      if (!mk[1] != mheld) begin
        if (mrun == N - 1) begin
          mheld <= !mheld;
          mrun  <= 0;
          if (!mheld) begin
            if (ms2) my <= md2;
            else     mx <= md2;
            mt <= ms2;
          end
        end else begin
          mrun <= mrun + 1;
        end
      end else begin
        mrun <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [9:0] exp);
    vectors++;
    if (LEDR !== exp) begin
      fails++;
      $display("FAIL %s: LEDR=%h expected %h", name, LEDR, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  typedef struct {
    logic [9:0] sw;
    logic       key_n;
    int         ncyc;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{10'h00A, 1'b1, 12, 10'h2F0};  // release after reset-time capture
    tbl[1]  = '{10'h00A, 1'b0, 10, 10'h1FA};  // clean press -> X=A
    tbl[2]  = '{10'h00A, 1'b1, 12, 10'h0FA};
    tbl[3]  = '{10'h205, 1'b1,  3, 10'h0FA};  // switches alone never capture
    tbl[4]  = '{10'h205, 1'b0, 10, 10'h35A};  // press -> Y=5, target 1
    tbl[5]  = '{10'h205, 1'b1, 12, 10'h25A};
    tbl[6]  = '{10'h00C, 1'b0,  3, 10'h25A};  // N-1 samples pressed: rejected
    tbl[7]  = '{10'h00C, 1'b1, 10, 10'h25A};
    tbl[8]  = '{10'h00C, 1'b0,  4, 10'h25A};  // exactly N samples pressed
    tbl[9]  = '{10'h00C, 1'b1,  1, 10'h25A};  // accept cycle, not yet captured
    tbl[10] = '{10'h00C, 1'b1, 10, 10'h05C};  // captured X=C then released

    RESET_N = 1'b0;
    SW      = 10'h3FF;
    KEY_N   = 1'b0;
    #1 chk("reset", 10'h000);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("reset_hold", 10'h000);
    RESET_N = 1'b1;
    step(5);
    chk("rst_key_pre_capture", 10'h000);
    step(1);
    chk("rst_key_capture", 10'h3F0);

    for (int i = 0; i < 11; i++) begin
      SW    = tbl[i].sw;
      KEY_N = tbl[i].key_n;
      step(tbl[i].ncyc);
      chk($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // press bounce: 3 low, 1 high, 3 low
    KEY_N = 1'b0; step(3);
    KEY_N = 1'b1; step(1);
    KEY_N = 1'b0; step(3);
    KEY_N = 1'b1; step(10);
    chk("press_bounce", 10'h05C);

    // long hold with data changing every cycle; capture sees the 4th word driven
    for (int i = 0; i < 50; i++) begin
      SW    = {6'b0, 4'((i % 15) + 1)};
      KEY_N = 1'b0;
      step(1);
    end
    chk("hold_one_capture", 10'h154);

    // release bounce: high 2, low 1, high 5
    KEY_N = 1'b1; step(2);
    KEY_N = 1'b0; step(1);
    KEY_N = 1'b1; step(5);
    chk("release_bounce_held", 10'h154);
    step(4);
    chk("release_done", 10'h054);

    // reset pulse while PRESS_DB count is 2; key still down afterwards
    SW    = 10'h207;
    KEY_N = 1'b0;
    step(4);
    RESET_N = 1'b0;
    #1 chk("reset_mid_debounce", 10'h000);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    step(5);
    chk("post_reset_pre_capture", 10'h000);
    step(1);
    chk("post_reset_capture", 10'h370);

    // random bursts: varying run lengths exercise bounces, accepts and releases
    for (int b = 0; b < 300; b++) begin
      int len;
      len   = $urandom_range(1, 8);
      KEY_N = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        SW = 10'($urandom);
        step(1);
        chk("random", {mt, mheld, my, mx});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
